counter_bank: RTL
=================

COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counter channels (1..8).
REQ-002 Parameter WIDTH, default 32: count width per channel.
REQ-003 Parameter PRESC_W, default 26: prescaler divisor width.
REQ-004 Parameter DEF_DIV, default 500000: divisor loaded into every channel at reset.
REQ-005 Parameter DEF_MODE, default 2'b01: mode loaded into every channel at reset.
REQ-006 clk  in  1  system clock; the only clock in the block.
REQ-007 n_rst  in  1  reset, asynchronous, active-high.
REQ-008 cfg_we  in  1  one-cycle configuration write strobe.
REQ-009 cfg_ch  in  CW=max(1,clog2(CHANNELS))  channel addressed by cfg_we.
REQ-010 cfg_div  in  PRESC_W  prescaler divisor to write.
REQ-011 cfg_mode  in  2  mode to write: 00 stop, 01 up-wrap, 10 down-wrap, 11 up-saturate.
REQ-012 clr  in  CHANNELS  per-channel synchronous clear.
REQ-013 sel  in  CW  channel routed to disp_dat.
REQ-014 count_all  out  CHANNELS*WIDTH  all counts; channel i at bits [i*WIDTH +: WIDTH].
REQ-015 tick  out  CHANNELS  one-cycle prescaler pulse per channel.
REQ-016 ovf  out  CHANNELS  sticky wrap/saturate flag per channel.
REQ-017 disp_dat  out  WIDTH  registered count of channel sel, for the TM1638 display driver.

Function
REQ-018 Each channel's prescaler SHALL count 0..div-1 and restart at 0; div=0 SHALL be treated as div=1.
REQ-019 tick[i] SHALL be high for exactly one clk cycle when prescaler i equals div-1 and mode is not stop; in stop mode the prescaler SHALL hold its value and tick SHALL stay 0.
REQ-020 The count SHALL update on the clk edge ending a tick cycle, so the new value is visible the cycle after tick.
REQ-021 Up-wrap: count+1 modulo 2^WIDTH; the transition max -> 0 SHALL set ovf.
REQ-022 Down-wrap: count-1 modulo 2^WIDTH; the transition 0 -> max SHALL set ovf.
REQ-023 Up-saturate: count SHALL increment to max and hold there; a tick while at max SHALL set ovf.
REQ-024 ovf[i] SHALL stay set until clr[i] or reset.
REQ-025 clr[i] SHALL zero count, prescaler, and ovf of channel i on the next edge, with priority over a coincident tick.
REQ-026 A cfg_we SHALL load div and mode into channel cfg_ch and zero its prescaler on the next edge; count and ovf SHALL be unchanged.
REQ-027 cfg_we with cfg_ch >= CHANNELS SHALL be ignored.
REQ-028 A coincident cfg_we and clr on the same channel SHALL both take effect.
REQ-029 A cfg_we coinciding with a tick SHALL let the tick's count update complete.
REQ-030 disp_dat SHALL equal the count of channel sel one cycle after sel or that count changes; sel >= CHANNELS SHALL yield 0.
REQ-031 All state SHALL be clocked by clk only; tick SHALL never be used as a clock.

Reset
REQ-032 While n_rst is high, all counts, prescalers, ovf, tick, and disp_dat SHALL be 0, div SHALL be DEF_DIV, and mode SHALL be DEF_MODE.
REQ-033 Reset asserted mid-count SHALL take effect immediately, without waiting for clk; counting SHALL resume on the first clk edge after release.

Structure
REQ-034 Mode encodings and the CW width function SHALL live in the shared package counter_bank_pkg.
REQ-035 The per-channel prescaler, count, and ovf logic SHALL be the sub-module counter_bank_channel, instantiated CHANNELS times with a generate loop.

Verification
REQ-036 Test 1: write div=3, mode=01 on ch0, idle 12 cycles -> tick0 every 3rd cycle and count0 = 4.
REQ-037 Test 2: WIDTH=8, ch1 up-wrap from 255 -> 0 with ovf1=1; clr1 -> count1=0 and ovf1=0.
REQ-038 Test 3: ch2 mode=10 from 0 -> 255 (WIDTH=8) with ovf2=1; mode=11 from 254 -> 255, holds at 255, ovf=1.
REQ-039 Test 4: clr0 and tick0 in the same cycle -> count0=0; cfg_we and clr on ch3 together -> new div applied and count3=0.
REQ-040 Test 5: assert n_rst between clk edges mid-count -> all outputs 0 immediately; after release, tick0 first appears DEF_DIV cycles later.
REQ-041 Test 6: switch sel 0->2 -> disp_dat equals count2 one cycle later; sel=CHANNELS -> disp_dat=0.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: channel mode encodings and
// the channel-select width helper.
package counter_bank_pkg;

    typedef enum logic [1:0] {
        MODE_STOP = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_SAT  = 2'b11
    } mode_e;

    // Channel-select width; a single channel still needs a 1-bit selector.
    function automatic int unsigned cw_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One counter channel: prescaler, count register and sticky overflow flag,
// configured through a per-channel write strobe.
module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESC_W  = 26,
    parameter int unsigned DEF_DIV  = 500000,
    parameter logic [1:0]  DEF_MODE = 2'b01
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               cfg_we,
    input  logic [PRESC_W-1:0] cfg_div,
    input  logic [1:0]         cfg_mode,
    input  logic               clr,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               ovf
);

    localparam logic [PRESC_W-1:0] RST_DIV  = PRESC_W'(DEF_DIV);
    localparam mode_e              RST_MODE = mode_e'(DEF_MODE);

    logic [PRESC_W-1:0] div_q,   div_d;
    mode_e              mode_q,  mode_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               ovf_q,   ovf_d;

    logic [PRESC_W-1:0] div_eff;
    logic               tick_raw;

    assign div_eff  = (div_q == '0) ? PRESC_W'(1) : div_q;
    assign tick_raw = (mode_q != MODE_STOP) && (presc_q == div_eff - PRESC_W'(1));
    // Reset forces tick low even when the reset divisor makes it permanently due.
    assign tick     = tick_raw & ~n_rst;

    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (mode_q != MODE_STOP) begin
            presc_d = tick_raw ? '0 : presc_q + PRESC_W'(1);
        end

        if (tick_raw) begin
            case (mode_q)
                MODE_UP: begin
                    count_d = count_q + WIDTH'(1);
                    if (count_q == '1) ovf_d = 1'b1;
                end
                MODE_DOWN: begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == '0) ovf_d = 1'b1;
                end
                MODE_SAT: begin
                    if (count_q == '1) ovf_d = 1'b1;
                    else               count_d = count_q + WIDTH'(1);
                end
                default: ;
            endcase
        end

        // A write acts on the settings only; the tick above still used the old mode.
        if (cfg_we) begin
            div_d   = cfg_div;
            mode_d  = mode_e'(cfg_mode);
            presc_d = '0;
        end

        if (clr) begin
            count_d = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            div_q   <= RST_DIV;
            mode_q  <= RST_MODE;
            presc_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent prescaled counters with a registered display tap
// feeding the TM1638 display driver.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESC_W  = 26,
    parameter int unsigned DEF_DIV  = 500000,
    parameter logic [1:0]  DEF_MODE = 2'b01,
    localparam int unsigned CW      = cw_f(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_ch,
    input  logic [PRESC_W-1:0]        cfg_div,
    input  logic [1:0]                cfg_mode,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CW-1:0]             sel,
    output logic [CHANNELS*WIDTH-1:0] count_all,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       ovf,
    output logic [WIDTH-1:0]          disp_dat
);

    logic [WIDTH-1:0] disp_q, disp_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic we_ch;

        // Out-of-range channel numbers match no instance and are dropped.
        assign we_ch = cfg_we && (cfg_ch == CW'(i));

        counter_bank_channel #(
            .WIDTH    (WIDTH),
            .PRESC_W  (PRESC_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE)
        ) u_ch (
            .clk      (clk),
            .n_rst    (n_rst),
            .cfg_we   (we_ch),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .clr      (clr[i]),
            .count    (count_all[i*WIDTH +: WIDTH]),
            .tick     (tick[i]),
            .ovf      (ovf[i])
        );
    end

    always_comb begin
        disp_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == CW'(i)) disp_d = count_all[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) disp_q <= '0;
        else       disp_q <= disp_d;
    end

    assign disp_dat = disp_q;

endmodule
